mda_vram_sched: RTL and testbench

MDA_VRAM_SCHED -- requirements
Module: mda_vram_sched

---
 rtl/mda_pkg.sv | 31 +++
 rtl/mda_blink_gen.sv | 47 ++++
 rtl/mda_vram_sched.sv | 142 ++++++++++++++
 tb/tb_mda_vram_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mda_pkg.sv
// Shared constants and helpers for the MDA video RAM scheduler.
package mda_pkg;

  // One character cell is nine dot clocks wide.
  localparam int CHAR_SLOTS   = 9;
  localparam int SLOT_CHAR    = 0;
  localparam int SLOT_ATTR    = 1;
  localparam int SLOT_CPU     = 3;
  localparam int SLOT_LOAD    = 8;
  localparam int BLINK_FRAMES = 16;

  // Derived slots: attribute data returns one slot after its address,
  // CPU read data returns one slot after the CPU slot.
  localparam int SLOT_ATTR_DATA = SLOT_ATTR + 1;
  localparam int SLOT_ACK       = SLOT_CPU + 1;

  localparam int SLOT_W  = $clog2(CHAR_SLOTS);
  localparam int FRAME_W = $clog2(BLINK_FRAMES);

  typedef logic [SLOT_W-1:0] slot_t;

  // Wrap 8 -> 0 unconditionally.
  function automatic slot_t next_slot(slot_t s);
    return (s == slot_t'(CHAR_SLOTS - 1)) ? '0 : s + slot_t'(1);
  endfunction

  function automatic logic is_slot(slot_t s, int n);
    return s == slot_t'(n);
  endfunction

endpackage

// File: rtl/mda_blink_gen.sv
// Blink phase generator: counts vsync rising edges and toggles the blink
// phase every BLINK_FRAMES frames (full blink period = 2*BLINK_FRAMES).
module mda_blink_gen
  import mda_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic vsync,
  output logic blink
);

  logic               vsync_q;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               blink_q, blink_d;
  logic               vsync_rise;

  // Next-state: count one frame per vsync rising edge, toggle on wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    frame_d    = frame_q;
    blink_d    = blink_q;
    vsync_rise = vsync & ~vsync_q;
    if (vsync_rise) begin
      frame_d = frame_q + FRAME_W'(1);
      if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) blink_d = ~blink_q;
    end
  end

  // State registers; a held-high vsync only produces one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      frame_q <= '0;
      blink_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      vsync_q <= vsync;
      frame_q <= frame_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/mda_vram_sched.sv
// MDA text-mode VRAM slot scheduler. Each 9-dot character cell fetches the
// character byte (slot 0) and attribute byte (slot 1), offers one CPU access
// in slot 3, and hands both display bytes to the pixel shifter in slot 8.
// Display fetches occupy fixed slots, so CPU traffic can never delay them.
module mda_vram_sched
  import mda_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-2:0] crtc_addr,
  input  logic          vsync,
  input  logic          bus_req,
  input  logic          bus_we,
  input  logic [AW-1:0] bus_addr,
  input  logic [7:0]    bus_din,
  output logic [7:0]    bus_dout,
  output logic          bus_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout,
  output logic [7:0]    char_byte,
  output logic [7:0]    att_byte,
  output logic          char_load,
  output logic          blink
);

  slot_t         slot_q, slot_d;
  logic [AW-2:0] crtc_q, crtc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    dout_q, dout_d;
  logic          rd_pend_q, rd_pend_d;
  logic [7:0]    char_stage_q, char_stage_d;
  logic [7:0]    att_stage_q, att_stage_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    att_q, att_d;
  logic          load_q, load_d;
  logic          grant;

  // Slot decode: RAM port, CPU handshake and display staging.
  always_comb begin
    slot_d       = next_slot(slot_q);
    crtc_d       = crtc_q;
    addr_d       = addr_q;
    din_d        = din_q;
    dout_d       = dout_q;
    rd_pend_d    = 1'b0;
    char_stage_d = char_stage_q;
    att_stage_d  = att_stage_q;
    char_d       = char_q;
    att_d        = att_q;
    load_d       = 1'b0;
    ram_we       = 1'b0;
    bus_ack      = 1'b0;
    grant        = is_slot(slot_q, SLOT_CPU) && bus_req;

    // Character fetch; the CRTC address is held for the attribute fetch.
    if (is_slot(slot_q, SLOT_CHAR)) begin
      addr_d = {crtc_addr, 1'b0};
      crtc_d = crtc_addr;
    end

    // Attribute fetch; character byte from slot 0 arrives now.
    if (is_slot(slot_q, SLOT_ATTR)) begin
      addr_d       = {crtc_q, 1'b1};
      char_stage_d = ram_dout;
    end

    if (is_slot(slot_q, SLOT_ATTR_DATA)) att_stage_d = ram_dout;

    // CPU slot: writes complete immediately, reads return next slot.
    if (grant) begin
      addr_d    = bus_addr;
      din_d     = bus_din;
      ram_we    = bus_we;
      bus_ack   = bus_we;
      rd_pend_d = ~bus_we;
    end

    if (is_slot(slot_q, SLOT_ACK) && rd_pend_q) begin
      dout_d  = ram_dout;
      bus_ack = 1'b1;
    end

    // Load the output pair on the edge entering the load slot so that
    // char_byte/att_byte and char_load are all visible during that slot.
    if (is_slot(slot_q, SLOT_LOAD - 1)) begin
      char_d = char_stage_q;
      att_d  = att_stage_q;
      load_d = 1'b1;
    end
  end

  // Scheduler state; reset aborts any in-flight CPU read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q       <= '0;
      crtc_q       <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      dout_q       <= '0;
      rd_pend_q    <= 1'b0;
      char_stage_q <= '0;
      att_stage_q  <= '0;
      char_q       <= '0;
      att_q        <= '0;
      load_q       <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      crtc_q       <= crtc_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      dout_q       <= dout_d;
      rd_pend_q    <= rd_pend_d;
      char_stage_q <= char_stage_d;
      att_stage_q  <= att_stage_d;
      char_q       <= char_d;
      att_q        <= att_d;
      load_q       <= load_d;
    end
  end

  // The RAM address is presented in the slot that owns it; during reset
  // slot 0 would otherwise drive the live CRTC address, so force it to 0.
  assign ram_addr  = reset_n ? addr_d : '0;
  assign ram_din   = din_d;
  assign bus_dout  = dout_d;
  assign char_byte = char_q;
  assign att_byte  = att_q;
  assign char_load = load_q;

  mda_blink_gen u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .vsync   (vsync),
    .blink   (blink)
  );

endmodule

// File: tb/tb_mda_vram_sched.sv
// Directed bench for mda_vram_sched with a registered-read VRAM model.
module tb_mda_vram_sched;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-2:0] crtc_addr;
  logic          vsync;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_din, bus_dout;
  logic          bus_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din, ram_dout;
  logic [7:0]    char_byte, att_byte;
  logic          char_load, blink;

  logic [7:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;
  int slot  = 0;

  typedef struct {
    logic [AW-2:0] crtc;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [7:0]    ch;
    logic [7:0]    at;
  } vec_t;

  vec_t vecs [4];

  mda_vram_sched #(.AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .crtc_addr (crtc_addr),
    .vsync     (vsync),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_din   (bus_din),
    .bus_dout  (bus_dout),
    .bus_ack   (bus_ack),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .char_byte (char_byte),
    .att_byte  (att_byte),
    .char_load (char_load),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic logic [7:0] pat(logic [AW-1:0] a);
    return a[7:0] ^ 8'h3C ^ {a[11:8], a[11:8]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; the bench tracks which slot the DUT should be in.
  task automatic step();
    @(posedge clk);
    #1;
    slot = (slot == 8) ? 0 : slot + 1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic goto_slot(int s);
    step();
    while (slot != s) step();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    slot    = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, loads, bad_ack_chars, dout_err, char_err, ack_this;
    logic [AW-2:0] cur_crtc;

    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
    mem[12'h246] = 8'h41; mem[12'h247] = 8'h70;
    mem[12'h000] = 8'h20; mem[12'h001] = 8'h07;
    mem[12'hFFE] = 8'hDB; mem[12'hFFF] = 8'h0F;
    mem[12'hAAA] = 8'h5C; mem[12'hAAB] = 8'h8F;
    mem[12'h010] = 8'h5A;

    vecs[0] = '{crtc: 11'h123, a0: 12'h246, a1: 12'h247, ch: 8'h41, at: 8'h70};
    vecs[1] = '{crtc: 11'h000, a0: 12'h000, a1: 12'h001, ch: 8'h20, at: 8'h07};
    vecs[2] = '{crtc: 11'h7FF, a0: 12'hFFE, a1: 12'hFFF, ch: 8'hDB, at: 8'h0F};
    vecs[3] = '{crtc: 11'h555, a0: 12'hAAA, a1: 12'hAAB, ch: 8'h5C, at: 8'h8F};

    reset_n   = 1'b0;
    crtc_addr = 11'h123;
    vsync     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_din   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_we", ram_we, 0);
    check("rst bus_ack", bus_ack, 0);
    check("rst char_load", char_load, 0);
    check("rst char_byte", char_byte, 0);
    check("rst blink", blink, 0);
    release_reset();

    // Table: display fetch addresses and output pairs, no CPU traffic
    goto_slot(8);
    crtc_addr = vecs[0].crtc;
    for (int v = 0; v < 4; v++) begin
      step(); settle();
      check("slot0 ram_addr", ram_addr, vecs[v].a0);
      check("slot0 ram_we", ram_we, 0);
      step();
      crtc_addr = ~vecs[v].crtc;
      settle();
      check("slot1 ram_addr", ram_addr, vecs[v].a1);
      goto_slot(7); settle();
      check("slot7 char_load", char_load, 0);
      step(); settle();
      check("slot8 char_load", char_load, 1);
      check("slot8 char_byte", char_byte, vecs[v].ch);
      check("slot8 att_byte", att_byte, vecs[v].at);
      if (v < 3) crtc_addr = vecs[v+1].crtc;
    end
    step(); settle();
    check("slot0 char_load low", char_load, 0);

    // CPU read raised at slot 1 is served in the same character
    goto_slot(1);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 12'h010;
    step(); settle();
    check("rd slot2 ack", bus_ack, 0);
    step(); settle();
    check("rd slot3 ram_addr", ram_addr, 12'h010);
    check("rd slot3 ram_we", ram_we, 0);
    check("rd slot3 ack", bus_ack, 0);
    step(); settle();
    check("rd slot4 ack", bus_ack, 1);
    check("rd slot4 dout", bus_dout, 8'h5A);
    step();
    bus_req = 1'b0;
    settle();
    check("rd slot5 ack", bus_ack, 0);
    check("rd slot5 ram_addr hold", ram_addr, 12'h010);

    // CPU write raised at slot 4 waits for the next character
    goto_slot(4);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 12'h020; bus_din = 8'hC3;
    acks = 0;
    settle();
    if (bus_ack) acks++;
    do begin
      step(); settle();
      if (bus_ack) acks++;
      if (ram_we) acks++;
    end while (slot != 2);
    check("wr early acks", acks, 0);
    step(); settle();
    check("wr slot3 ram_we", ram_we, 1);
    check("wr slot3 ack", bus_ack, 1);
    check("wr slot3 ram_addr", ram_addr, 12'h020);
    check("wr slot3 ram_din", ram_din, 8'hC3);
    step();
    bus_req = 1'b0; bus_we = 1'b0;
    settle();
    check("wr slot4 ack", bus_ack, 0);
    check("wr slot4 ram_we", ram_we, 0);
    step();
    bus_req = 1'b1; bus_addr = 12'h020;
    goto_slot(4); settle();
    check("readback ack", bus_ack, 1);
    check("readback dout", bus_dout, 8'hC3);
    step();
    bus_req = 1'b0;

    // Continuous CPU reads over 100 characters
    goto_slot(8);
    cur_crtc  = 11'h300;
    crtc_addr = cur_crtc;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 12'h700;
    acks = 0; loads = 0; bad_ack_chars = 0; dout_err = 0; char_err = 0;
    for (int i = 0; i < 100; i++) begin
      ack_this = 0;
      for (int k = 0; k < 9; k++) begin
        step(); settle();
        if (bus_ack) begin
          ack_this++;
          acks++;
          if (bus_dout !== pat(bus_addr)) dout_err++;
        end
        if (k == 5) bus_addr = 12'h700 + AW'(i + 1);
        if (char_load) begin
          loads++;
          if (char_byte !== pat({cur_crtc, 1'b0}) || att_byte !== pat({cur_crtc, 1'b1}))
            char_err++;
        end
        if (k == 8) begin
          cur_crtc  = 11'h300 + 11'((i + 1) * 3);
          crtc_addr = cur_crtc;
        end
      end
      if (ack_this != 1) bad_ack_chars++;
    end
    bus_req = 1'b0;
    check("cont total acks", acks, 100);
    check("cont chars without one ack", bad_ack_chars, 0);
    check("cont read data errors", dout_err, 0);
    check("cont char_load count", loads, 100);
    check("cont display byte errors", char_err, 0);

    // Blink: 32 vsync pulses, the fifth held high for 50 cycles
    for (int k = 1; k <= 32; k++) begin
      vsync = 1'b1;
      repeat ((k == 5) ? 50 : 2) step();
      vsync = 1'b0;
      repeat (3) step();
      settle();
      check($sformatf("blink after edge %0d", k), blink, (k >= 16 && k < 32) ? 1 : 0);
    end

    // Reset during slot 3 of a granted read
    goto_slot(1);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 12'h010;
    goto_slot(3); settle();
    check("abort slot3 ram_addr", ram_addr, 12'h010);
    reset_n = 1'b0;
    #1;
    check("abort ack", bus_ack, 0);
    check("abort ram_addr", ram_addr, 0);
    check("abort ram_we", ram_we, 0);
    check("abort ram_din", ram_din, 0);
    check("abort bus_dout", bus_dout, 0);
    check("abort char_byte", char_byte, 0);
    check("abort att_byte", att_byte, 0);
    check("abort char_load", char_load, 0);
    @(posedge clk); #2;
    check("abort ack held", bus_ack, 0);
    release_reset();
    acks = 0;
    settle();
    if (bus_ack) acks++;
    step(); settle(); if (bus_ack) acks++;
    step(); settle(); if (bus_ack) acks++;
    step(); settle();
    check("post-reset early acks", acks, 0);
    check("post-reset slot3 ram_addr", ram_addr, 12'h010);
    step(); settle();
    check("post-reset slot4 ack", bus_ack, 1);
    check("post-reset slot4 dout", bus_dout, 8'h5A);
    step();
    bus_req = 1'b0;
    settle();
    check("post-reset slot5 ack", bus_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
